// File: rtl/tff_pkg.sv
// Shared types and constants for the T flip-flop counter bank.
// Mode encoding is fixed; the mode width constant sizes the mode port.
// Imported by tff_cell and tff_bank_counter.
package tff_pkg;

    localparam int TFF_MODE_W = 2;

    typedef enum logic [TFF_MODE_W-1:0] {
        TFF_TOGGLE = 2'b00,
        TFF_UP     = 2'b01,
        TFF_DOWN   = 2'b10,
        TFF_HOLD   = 2'b11
    } tff_mode_t;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles q when i_t is high at a rising clk edge.
// Latency: 1 cycle from i_t to q/qb. No backpressure; reset (async, active-high)
// forces q=0, qb=1. qb is its own register so it never glitches relative to q.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic i_t,
    output logic o_q,
    output logic o_qb
);

    logic r_q;
    logic r_qb;

    // Toggle state and its complement together on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q  <= 1'b0;
            r_qb <= 1'b1;
        end else begin
            r_q  <= r_q ^ i_t;
            r_qb <= ~(r_q ^ i_t);
        end
    end

    assign o_q  = r_q;
    assign o_qb = r_qb;

endmodule : tff_cell

// File: rtl/tff_bank_counter.sv
// Bank of WIDTH T flip-flops acting as toggle register / modulo up-down counter with parallel load.
// Latency: q, qb, wrap 1 cycle after the sampling edge; tc is combinational from q and mode.
// No backpressure; i_en low freezes state. Define TFF_BANK_SAT_EN to saturate UP/DOWN instead of wrapping.
module tff_bank_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MOD   = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  tff_mode_t        i_mode,
    input  logic [WIDTH-1:0] i_t_mask,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qb,
    output logic             o_tc,
    output logic             o_wrap
);

    // Top of the count range, truncated to WIDTH bits; MOD = 2**WIDTH gives all ones,
    // which turns the compare-and-reload into a natural binary wrap.
    localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] LP_ZERO = '0;
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_t;
    logic             w_wrap_nxt;
    logic             w_tc;
    logic             r_wrap;

    // Next-state selection: enable, then load, then mode.
    always_comb begin
        w_next_q   = w_q;
        w_wrap_nxt = 1'b0;
        if (!i_en) begin
            w_next_q = w_q;
        end else if (i_load) begin
            // Loaded raw, even when outside the modulus range.
            w_next_q = i_load_val;
        end else begin
            case (i_mode)
                TFF_TOGGLE: begin
                    w_next_q = w_q ^ i_t_mask;
                end
                TFF_UP: begin
                    // >= rather than == so out-of-range loads fall back into range.
                    if (w_q >= LP_MAX) begin
`ifdef TFF_BANK_SAT_EN
                        w_next_q   = LP_MAX;
`else
                        w_next_q   = LP_ZERO;
                        w_wrap_nxt = 1'b1;
`endif
                    end else begin
                        w_next_q = w_q + LP_ONE;
                    end
                end
                TFF_DOWN: begin
                    // Out-of-range values simply decrement toward the range.
                    if (w_q == LP_ZERO) begin
`ifdef TFF_BANK_SAT_EN
                        w_next_q   = LP_ZERO;
`else
                        w_next_q   = LP_MAX;
                        w_wrap_nxt = 1'b1;
`endif
                    end else begin
                        w_next_q = w_q - LP_ONE;
                    end
                end
                default: begin
                    w_next_q = w_q;
                end
            endcase
        end
    end

    // Every state change is expressed as a toggle pattern on the cells.
    assign w_t = w_q ^ w_next_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .i_t   (w_t[gi]),
                .o_q   (w_q[gi]),
                .o_qb  (w_qb[gi])
            );
        end
    endgenerate

    // Wrap pulse: registered, high for exactly the cycle after a modulus wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

    // Terminal count depends only on current state and mode, never on enable.
    always_comb begin
        w_tc = 1'b0;
        case (i_mode)
            TFF_UP:   w_tc = (w_q == LP_MAX);
            TFF_DOWN: w_tc = (w_q == LP_ZERO);
            default:  w_tc = 1'b0;
        endcase
    end

    assign o_q    = w_q;
    assign o_qb   = w_qb;
    assign o_tc   = w_tc;
    assign o_wrap = r_wrap;

endmodule : tff_bank_counter
